// File: rtl/ram_arb_pkg.sv
// Shared types for the two-requester RAM port arbiter: request bundle,
// read-return tag and requester identifiers.
package ram_arb_pkg;

   localparam int RAM_DATA_W     = 128;
   localparam int RAM_STRB_W     = 16;
   // Widest word address the request bundle can carry; ADDR_WIDTH must not exceed it.
   localparam int RAM_ADDR_MAX_W = 16;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_e;

   typedef struct packed {
      logic [RAM_STRB_W-1:0]     we;
      logic [RAM_ADDR_MAX_W-1:0] addr;
      logic [RAM_DATA_W-1:0]     wdata;
   } ram_req_t;

   typedef struct packed {
      logic    valid;
      req_id_e id;
   } rd_tag_t;

   function automatic logic is_read(input logic [RAM_STRB_W-1:0] we);
      return we == '0;
   endfunction

endpackage

// File: rtl/ram_rd_tag_pipe.sv
// Delay line that carries the owner of each issued read alongside the RAM's
// read latency, so returning data can be steered back to its requester.
module ram_rd_tag_pipe
   import ram_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    clr,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out
);

   rd_tag_t stage_q [DEPTH];
   rd_tag_t stage_d [DEPTH];

   always_comb begin
      stage_d[0] = tag_in;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of one byte-enabled RAM port between two requesters,
// with a tag pipe that routes each read result back to its issuer.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 8,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  r0_valid,
   output logic                  r0_ready,
   input  logic [RAM_STRB_W-1:0] r0_we,
   input  logic [ADDR_WIDTH-1:0] r0_addr,
   input  logic [RAM_DATA_W-1:0] r0_wdata,
   output logic                  r0_rvalid,
   output logic [RAM_DATA_W-1:0] r0_rdata,

   input  logic                  r1_valid,
   output logic                  r1_ready,
   input  logic [RAM_STRB_W-1:0] r1_we,
   input  logic [ADDR_WIDTH-1:0] r1_addr,
   input  logic [RAM_DATA_W-1:0] r1_wdata,
   output logic                  r1_rvalid,
   output logic [RAM_DATA_W-1:0] r1_rdata,

   output logic                  ram_en,
   output logic [RAM_STRB_W-1:0] ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [RAM_DATA_W-1:0] ram_din,
   input  logic [RAM_DATA_W-1:0] ram_dout
);

   req_id_e  last_grant_q;
   req_id_e  last_grant_d;
   logic     grant0;
   logic     grant1;
   ram_req_t req0;
   ram_req_t req1;
   ram_req_t issue;
   rd_tag_t  tag_in;
   rd_tag_t  tag_out;

   // Under contention the requester that did not win last time gets the port.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rst) begin
         if (r0_valid && r1_valid) begin
            grant0 = (last_grant_q == REQ1);
            grant1 = (last_grant_q == REQ0);
         end else begin
            grant0 = r0_valid;
            grant1 = r1_valid;
         end
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (grant0) begin
         last_grant_d = REQ0;
      end else if (grant1) begin
         last_grant_d = REQ1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= REQ1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      req0.we    = r0_we;
      req0.addr  = RAM_ADDR_MAX_W'(r0_addr);
      req0.wdata = r0_wdata;
      req1.we    = r1_we;
      req1.addr  = RAM_ADDR_MAX_W'(r1_addr);
      req1.wdata = r1_wdata;
      issue      = grant1 ? req1 : req0;
   end

   assign r0_ready = grant0;
   assign r1_ready = grant1;
   assign ram_en   = grant0 | grant1;
   assign ram_we   = ram_en ? issue.we : '0;
   assign ram_addr = ADDR_WIDTH'(issue.addr);
   assign ram_din  = issue.wdata;

   always_comb begin
      tag_in.valid = ram_en && is_read(issue.we);
      tag_in.id    = grant1 ? REQ1 : REQ0;
   end

   ram_rd_tag_pipe #(
      .DEPTH (READ_LATENCY)
   ) u_tag_pipe (
      .clk     (clk),
      .clr     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // Data is shared; only the tag decides which requester sees a valid pulse.
   assign r0_rvalid = tag_out.valid && (tag_out.id == REQ0);
   assign r1_rvalid = tag_out.valid && (tag_out.id == REQ1);
   assign r0_rdata  = ram_dout;
   assign r1_rdata  = ram_dout;

endmodule
